// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-fed UART transmitter.
package uart_pkg;

   // Transmitter sequencing: pop a word, wait for it, then send the frame.
   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_e;

   // Widest word the parity helper handles; wider words would be truncated.
   localparam int MAX_DATA_WIDTH = 64;

   // Number of serial bit periods in one frame: start, data, optional parity, stop.
   function automatic int frame_bits(input int dataWidth, input int parityEn, input int stopBits);
      return 1 + dataWidth + parityEn + stopBits;
   endfunction

   // Even parity: the extra bit makes the total count of ones even.
   function automatic logic even_parity(input logic [MAX_DATA_WIDTH-1:0] data);
      return ^data;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_cnt #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   output logic bit_tick_o
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;

   // Free-running within a frame; held at zero while the transmitter is not shifting bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear_i || (cnt_q == LAST)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // The tick marks the final cycle of the current bit period.
   assign bit_tick_o = (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from a synchronous FIFO and sends them as serial frames.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_r_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  tx_done
);

   localparam int BIT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0] LAST_STOP_BIT = BIT_W'(STOP_BITS - 1);

   tx_state_e             state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [BIT_W-1:0]      bitCnt_q, bitCnt_d;
   logic                  parity_q, parity_d;
   logic                  tx_q, tx_d;
   logic                  rEn_q, rEn_d;
   logic                  baudClear;
   logic                  bitTick;

   // The bit-period counter only runs while a frame is actually on the line.
   assign baudClear = (state_q == IDLE) || (state_q == FETCH) || (state_q == LOAD);

   uart_baud_cnt #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) uBaud (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (baudClear),
      .bit_tick_o(bitTick)
   );

   // State, datapath and the registered line/strobe outputs; reset forces the line idle at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         bitCnt_q <= '0;
         parity_q <= 1'b0;
         tx_q     <= 1'b1;
         rEn_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         bitCnt_q <= bitCnt_d;
         parity_q <= parity_d;
         tx_q     <= tx_d;
         rEn_q    <= rEn_d;
      end
   end

   // Next-state logic; the line level and read strobe are derived from where we are going,
   // so both come straight out of flops with no decode glitches.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bitCnt_d = bitCnt_q;
      parity_d = parity_q;

      case (state_q)
         IDLE: begin
            if (tx_en && !fifo_empty) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            state_d = LOAD;
         end
         LOAD: begin
            shift_d  = fifo_data;
            parity_d = even_parity(MAX_DATA_WIDTH'(fifo_data));
            bitCnt_d = '0;
            state_d  = START;
         end
         START: begin
            if (bitTick) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (bitTick) begin
               shift_d = shift_q >> 1;
               if (bitCnt_q == LAST_DATA_BIT) begin
                  bitCnt_d = '0;
                  state_d  = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bitCnt_d = bitCnt_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (bitTick) begin
               bitCnt_d = '0;
               state_d  = STOP;
            end
         end
         STOP: begin
            if (bitTick) begin
               if (bitCnt_q == LAST_STOP_BIT) begin
                  bitCnt_d = '0;
                  state_d  = IDLE;
               end else begin
                  bitCnt_d = bitCnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      tx_d = 1'b1;
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = parity_d;
         default: tx_d = 1'b1;
      endcase

      rEn_d = (state_d == FETCH);
   end

   assign fifo_r_en = rEn_q;
   assign tx        = tx_q;
   assign busy      = (state_q != IDLE);
   assign tx_done   = (state_q == STOP) && bitTick && (bitCnt_q == LAST_STOP_BIT);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: three instances (plain, even parity, two stop bits)
// share one stimulus stream; each has its own FIFO model and expected-frame queue.
module tb_fifo_uart_tx;

   localparam int NI    = 3;
   localparam int CPB   = 4;
   localparam int DEPTH = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          txEn = 1'b0;
   logic [NI-1:0] fifoEmpty;
   logic [NI-1:0] rEn;
   logic [NI-1:0] txLine;
   logic [NI-1:0] busy;
   logic [NI-1:0] txDone;
   logic [7:0]    fifoData [NI] = '{default: 8'h00};

   logic [7:0] fifoMem [NI][DEPTH];
   int         fifoHead [NI] = '{default: 0};
   int         fifoTail [NI] = '{default: 0};

   logic [7:0] expMem [NI][DEPTH];
   int         expHead [NI];
   int         expTail [NI] = '{default: 0};

   int vectors = 0;
   int miscompares = 0;
   bit waitTimeout = 1'b0;
   bit finalReq = 1'b0;

   // Free-running system clock.
   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : gInst
      localparam int PE = (g == 1) ? 1 : 0;
      localparam int SB = (g == 2) ? 2 : 1;

      fifo_uart_tx #(
         .DATA_WIDTH  (8),
         .CLKS_PER_BIT(CPB),
         .PARITY_EN   (PE),
         .STOP_BITS   (SB)
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .tx_en     (txEn),
         .fifo_empty(fifoEmpty[g]),
         .fifo_data (fifoData[g]),
         .fifo_r_en (rEn[g]),
         .tx        (txLine[g]),
         .busy      (busy[g]),
         .tx_done   (txDone[g])
      );

      assign fifoEmpty[g] = (fifoHead[g] == fifoTail[g]);
   end

   function automatic int instParity(input int i);
      return (i == 1) ? 1 : 0;
   endfunction

   function automatic int instStops(input int i);
      return (i == 2) ? 2 : 1;
   endfunction

   // FIFO model: a read strobe seen at a rising edge makes the next word visible one cycle later.
   always @(posedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (rEn[i] && (fifoHead[i] != fifoTail[i])) begin
            fifoData[i] <= fifoMem[i][fifoHead[i] % DEPTH];
            fifoHead[i] <= fifoHead[i] + 1;
         end
      end
   end

   task automatic checkOutput(input string name, input int inst, input int got, input int want);
      vectors++;
      if (got != want) begin
         miscompares++;
         $display("[TB] FAIL %s inst%0d at %0t: got %0h, expected %0h", name, inst, $time, got, want);
      end
   endtask

   // Monitor: reconstructs each frame from the line, samples mid-bit, and checks it against
   // the scoreboard when the frame should end; timing rules are checked every cycle.
   initial begin
      int     cyc;
      int     lastREn [NI];
      int     n [NI];
      int     fetchCnt [NI];
      bit     inFrame [NI];
      bit     expREn [NI];
      logic [15:0] rxBits [NI];
      bit     finalDone;
      cyc = 0;
      finalDone = 1'b0;
      for (int i = 0; i < NI; i++) begin
         lastREn[i] = -100; n[i] = 0; fetchCnt[i] = 0;
         inFrame[i] = 1'b0; expREn[i] = 1'b0; rxBits[i] = '0; expHead[i] = 0;
      end
      forever begin
         @(negedge clk);
         if (finalReq && !finalDone) begin
            finalDone = 1'b1;
            checkOutput("wait_budget", 0, int'(waitTimeout), 0);
            for (int i = 0; i < NI; i++) begin
               checkOutput("frames_outstanding", i, expTail[i] - expHead[i], 0);
            end
         end
         if (rst) begin
            for (int i = 0; i < NI; i++) begin
               checkOutput("reset_outputs", i, int'({txLine[i], busy[i], rEn[i], txDone[i]}), 'b1000);
               if (fetchCnt[i] > 0 && expHead[i] != expTail[i]) begin
                  expHead[i]++;
               end
               lastREn[i] = -100; n[i] = 0; fetchCnt[i] = 0;
               inFrame[i] = 1'b0; expREn[i] = 1'b0;
            end
         end else begin
            cyc++;
            for (int i = 0; i < NI; i++) begin
               int  len;
               int  pe;
               int  sb;
               bit  wasIn;
               bit  stopOk;
               logic [7:0] want;
               pe  = instParity(i);
               sb  = instStops(i);
               len = (1 + 8 + pe + sb) * CPB;

               checkOutput("r_en", i, int'(rEn[i]), int'(expREn[i]));
               if (rEn[i]) begin
                  lastREn[i] = cyc;
                  fetchCnt[i]++;
               end
               if (!inFrame[i] && txLine[i] == 1'b0) begin
                  checkOutput("start_latency", i, cyc - lastREn[i], 2);
                  inFrame[i] = 1'b1;
                  n[i] = 0;
                  rxBits[i] = '0;
               end
               checkOutput("busy", i, int'(busy[i]), int'(inFrame[i] || (cyc - lastREn[i] <= 1)));
               checkOutput("tx_done", i, int'(txDone[i]), int'(inFrame[i] && n[i] == len - 1));

               wasIn = inFrame[i];
               if (inFrame[i]) begin
                  if (n[i] % CPB == CPB / 2) begin
                     rxBits[i][n[i] / CPB] = txLine[i];
                  end
                  if (n[i] == len - 1) begin
                     if (expHead[i] == expTail[i]) begin
                        checkOutput("unexpected_frame", i, 1, 0);
                     end else begin
                        want = expMem[i][expHead[i] % DEPTH];
                        expHead[i]++;
                        checkOutput("start_bit", i, int'(rxBits[i][0]), 0);
                        checkOutput("data", i, int'(rxBits[i][8:1]), int'(want));
                        if (pe == 1) begin
                           checkOutput("parity", i, int'(rxBits[i][9]), $countones(want) % 2);
                        end
                        stopOk = 1'b1;
                        for (int k = 9 + pe; k < 9 + pe + sb; k++) begin
                           stopOk = stopOk & rxBits[i][k];
                        end
                        checkOutput("stop_bits", i, int'(stopOk), 1);
                        checkOutput("fetches_per_frame", i, fetchCnt[i], 1);
                     end
                     fetchCnt[i] = 0;
                     inFrame[i] = 1'b0;
                  end
                  n[i]++;
               end
               expREn[i] = !wasIn && (cyc - lastREn[i] > 1) && txEn && !fifoEmpty[i];
            end
         end
      end
   end

   task automatic stepCycles(input int count);
      repeat (count) @(posedge clk);
      #1;
   endtask

   // Queue one word in every FIFO model and record it as the expected frame payload.
   task automatic applyStimulus(input logic [7:0] b);
      for (int i = 0; i < NI; i++) begin
         fifoMem[i][fifoTail[i] % DEPTH] = b;
         fifoTail[i] = fifoTail[i] + 1;
         expMem[i][expTail[i] % DEPTH] = b;
         expTail[i] = expTail[i] + 1;
      end
   endtask

   task automatic waitDrain(input int budget);
      bit done;
      done = 1'b0;
      for (int k = 0; k < budget && !done; k++) begin
         @(negedge clk);
         done = 1'b1;
         for (int i = 0; i < NI; i++) begin
            if (!fifoEmpty[i] || busy[i]) done = 1'b0;
         end
      end
      if (!done) waitTimeout = 1'b1;
      stepCycles(1);
   endtask

   task automatic waitTxLow(input int budget);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         if (txLine[0] == 1'b0) seen = 1'b1;
      end
      if (!seen) waitTimeout = 1'b1;
   endtask

   // Stimulus sequence: idle after reset, single frames, bursts, enable gating, reset mid-frame, random.
   initial begin
      rst  = 1'b1;
      txEn = 1'b0;
      stepCycles(5);
      rst  = 1'b0;
      txEn = 1'b1;
      stepCycles(50);

      $display("[TB] single frames 0xA5, 0x07, 0x03");
      applyStimulus(8'hA5);
      waitDrain(200);
      applyStimulus(8'h07);
      waitDrain(200);
      applyStimulus(8'h03);
      waitDrain(200);

      $display("[TB] back-to-back burst");
      txEn = 1'b0;
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      stepCycles(2);
      txEn = 1'b1;
      waitDrain(400);
      stepCycles(20);

      $display("[TB] enable dropped mid-frame");
      txEn = 1'b0;
      applyStimulus(8'h5C);
      applyStimulus(8'hE1);
      stepCycles(2);
      txEn = 1'b1;
      waitTxLow(20);
      stepCycles(12);
      txEn = 1'b0;
      stepCycles(80);
      txEn = 1'b1;
      waitDrain(300);

      $display("[TB] reset during data bit 3");
      txEn = 1'b0;
      applyStimulus(8'h96);
      applyStimulus(8'h4B);
      stepCycles(2);
      txEn = 1'b1;
      waitTxLow(20);
      stepCycles(18);
      rst = 1'b1;
      stepCycles(3);
      rst = 1'b0;
      waitDrain(300);

      $display("[TB] randomized traffic");
      for (int k = 0; k < 16; k++) begin
         applyStimulus(8'($urandom_range(0, 255)));
         if ($urandom_range(0, 3) == 0) txEn = ~txEn;
         stepCycles($urandom_range(1, 40));
      end
      txEn = 1'b1;
      waitDrain(2000);
      stepCycles(10);

      finalReq = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream consumer of the synchronous FIFO. Pops one word at a time over the FIFO read interface (r_en / data_out / empty) and serialises it as an asynchronous UART frame on a single tx line. Frame format: start bit, LSB-first data, optional even parity, one or two stop bits. Sits between the FIFO and the chip pad / serial link.

Parameters:
DATA_WIDTH, 8, word width; must match the FIFO DATA_WIDTH.
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range is 2 or more.
PARITY_EN, 0, 1 inserts an even-parity bit after the data bits.
STOP_BITS, 1, number of stop bits; legal values are 1 or 2.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  asynchronous, active-high reset.
tx_en  in  1  1 allows new frames to start; a frame already in flight always completes.
fifo_empty  in  1  FIFO empty flag.
fifo_data  in  DATA_WIDTH  FIFO data_out; valid the cycle after the cycle in which r_en is high.
fifo_r_en  out  1  FIFO read strobe; registered; single-cycle pulse.
tx  out  1  serial line; registered; idle level is 1.
busy  out  1  high from FETCH through the last stop-bit cycle.
tx_done  out  1  single-cycle pulse at the end of each frame.

Behaviour:
- Reset (async, while rst=1): state=IDLE, tx=1, fifo_r_en=0, busy=0, tx_done=0, bit/baud counters=0, shift register=0. Reset asserted mid-frame aborts the frame immediately; tx returns to 1 with no glitch to 0.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1. At a clock edge where tx_en=1 and fifo_empty=0, go to FETCH. Otherwise stay in IDLE.
- FETCH: exactly one cycle, with fifo_r_en=1. Go to LOAD.
- LOAD: one cycle; fifo_r_en=0. At the end of LOAD, capture fifo_data into the shift register and compute parity. Go to START.
- Latency: the edge that leaves IDLE is E0. tx falls at E2, so the start bit begins 2 edges after the sampled request.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: DATA_WIDTH bits, LSB first. Each bit is held CLKS_PER_BIT cycles, then the shift register shifts right.
- PARITY: present only if PARITY_EN=1. tx = XOR of all data bits (even parity) for CLKS_PER_BIT cycles.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. On the final cycle, tx_done=1 and the state returns to IDLE.
- Frame length: (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- Back-to-back frames: the minimum gap is 3 extra tx-high cycles (IDLE, FETCH, LOAD) after the stop bits.
- At most one fifo_r_en pulse per frame. fifo_r_en is never asserted when fifo_empty=1 was sampled in IDLE.
- tx_en falling mid-frame: the current frame finishes normally and no new FETCH starts. fifo_empty changes outside IDLE are ignored.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary. Its width is clog2(CLKS_PER_BIT). The bit counter width is clog2(DATA_WIDTH+1).
- busy=1 in every state except IDLE.

Decomposition:
- Shared package uart_pkg:
  - state enum tx_state_e;
  - localparam FRAME_BITS derivation;
  - even-parity function.
- One sub-module, uart_baud_cnt: bit-period counter with clear and a bit_tick output (high on count==CLKS_PER_BIT-1). The FSM, shift register and bit counter remain in fifo_uart_tx.

Test Plan:
All scenarios use CLKS_PER_BIT=4 unless noted.
1. Reset/idle: hold rst=1, then release with fifo_empty=1 and tx_en=1 for 50 cycles -> tx=1, fifo_r_en=0, busy=0 throughout.
2. Single byte 0xA5, PARITY_EN=0 -> exactly one fifo_r_en pulse; tx falls 2 edges after the request. Bits sampled mid-period: 0,1,0,1,0,0,1,0,1,1. busy lasts 42 cycles (FETCH + LOAD + 40 frame cycles); one tx_done pulse.
3. Parity, PARITY_EN=1, byte 0x07 -> parity bit=1. Byte 0x03 -> parity bit=0. Frame is 44 cycles.
4. Back-to-back FIFO holding 0x11, 0x22, 0x33 -> three frames decoded in order; exactly 3 extra tx-high cycles between frames; 3 fifo_r_en pulses; after the third frame the block stays IDLE with fifo_empty=1.
5. tx_en cleared during DATA of the first of two queued bytes -> first frame completes, no second r_en; setting tx_en=1 again sends the second byte.
6. rst pulsed during DATA bit 3 -> tx=1 asynchronously, state IDLE, no tx_done. After release, the next queued byte transmits as a complete frame. STOP_BITS=2 variant: stop held 8 cycles.
